// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, types and width helper for the display scan controller
package display_pkg;

    localparam int MAX_DIGITS = 8;

    typedef logic [3:0] nibble_t;

    // Bits needed to hold 0..value-1; never less than 1 so single-value counters still get a bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/display_slot_timer.sv
// rtl/display_slot_timer.sv - slot counter and digit index for the display scan
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   slot_wrap    current cycle is the last cycle of a slot
//   frame_wrap   current cycle is the last cycle of the last digit's slot
//   in_blank     the upcoming cycle falls in the blanking part of its slot
//   idx          digit index of the current slot
module display_slot_timer
    import display_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      slot_wrap,
    output logic                      frame_wrap,
    output logic                      in_blank,
    output logic [clog2(DIGITS)-1:0]  idx
);

    localparam int CW = clog2(PRESCALE);
    localparam int IW = clog2(DIGITS);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [IW-1:0] idx_nxt;

    assign slot_wrap  = (cnt == CW'(PRESCALE - 1));
    assign frame_wrap = slot_wrap && (idx == IW'(DIGITS - 1));

    always_comb begin
        cnt_nxt = slot_wrap ? '0 : cnt + 1'b1;
        idx_nxt = idx;
        if (frame_wrap) begin
            idx_nxt = '0;
        end else if (slot_wrap) begin
            idx_nxt = idx + 1'b1;
        end
    end

    // Looks one cycle ahead so the registered digit enables line up with cnt.
    assign in_blank = (int'(cnt_nxt) < BLANK_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_nxt;
            idx <= idx_nxt;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - multiplexed scan controller for a common-anode 7-segment display
//
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   load_i         strobe: capture value_i/dp_i into the shadow register
//   value_i        4 bits per digit, digit 0 in bits [3:0]
//   dp_i           decimal-point request per digit
//   nibble_o       value of the digit in the current slot
//   dp_o           decimal point of the digit in the current slot
//   digit_en_n_o   active-low digit enables, at most one low
//   frame_o        one-cycle pulse at each frame start
//   pending_o      shadow holds a value not yet displayed
module display_scan_controller
    import display_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic [DIGITS-1:0]     dp_i,
    output logic [3:0]            nibble_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     digit_en_n_o,
    output logic                  frame_o,
    output logic                  pending_o
);

    localparam int IW = clog2(DIGITS);

    logic          slot_wrap;
    logic          frame_wrap;
    logic          in_blank;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_next;

    logic [4*DIGITS-1:0] shadow_val;
    logic [DIGITS-1:0]   shadow_dp;
    logic [4*DIGITS-1:0] active_val;
    logic [DIGITS-1:0]   active_dp;
    logic [4*DIGITS-1:0] active_val_nxt;
    logic [DIGITS-1:0]   active_dp_nxt;
    logic [DIGITS-1:0]   suppress;
    logic [DIGITS-1:0]   en_n_nxt;
    nibble_t             nibble_nxt;

    display_slot_timer #(
        .DIGITS       (DIGITS),
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .slot_wrap  (slot_wrap),
        .frame_wrap (frame_wrap),
        .in_blank   (in_blank),
        .idx        (idx)
    );

    // Outputs are registered from next-cycle state so they stay aligned with the slot counter.
    always_comb begin
        idx_next = idx;
        if (frame_wrap) begin
            idx_next = '0;
        end else if (slot_wrap) begin
            idx_next = idx + 1'b1;
        end
    end

    // Boundary transfer uses the shadow as it stood before any same-cycle load.
    always_comb begin
        active_val_nxt = active_val;
        active_dp_nxt  = active_dp;
        if (frame_wrap && pending_o) begin
            active_val_nxt = shadow_val;
            active_dp_nxt  = shadow_dp;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; suppression stops at the first nonzero digit or dp request.
    logic zero_run;
    always_comb begin
        suppress = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run    = zero_run && (active_val_nxt[4*i +: 4] == 4'h0) && !active_dp_nxt[i];
            suppress[i] = zero_run;
        end
    end
`else
    assign suppress = '0;
`endif

    always_comb begin
        nibble_nxt = active_val_nxt[4*idx_next +: 4];
        en_n_nxt   = '1;
        if (!in_blank && !suppress[idx_next]) begin
            en_n_nxt[idx_next] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val   <= '0;
            shadow_dp    <= '0;
            active_val   <= '0;
            active_dp    <= '0;
            pending_o    <= 1'b0;
            nibble_o     <= '0;
            dp_o         <= 1'b0;
            digit_en_n_o <= '1;
            frame_o      <= 1'b0;
        end else begin
            if (load_i) begin
                shadow_val <= value_i;
                shadow_dp  <= dp_i;
            end
            if (load_i) begin
                pending_o <= 1'b1;
            end else if (frame_wrap) begin
                pending_o <= 1'b0;
            end
            active_val   <= active_val_nxt;
            active_dp    <= active_dp_nxt;
            nibble_o     <= nibble_nxt;
            dp_o         <= active_dp_nxt[idx_next];
            digit_en_n_o <= en_n_nxt;
            frame_o      <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - self-checking bench for display_scan_controller
module tb_display_scan_controller;

    localparam int DIGITS = 4;
    localparam int PRESCALE = 8;
    localparam int BLANK = 2;
    localparam int FRAME = DIGITS * PRESCALE;

    logic        clk;
    logic        rst_n;
    logic        load_i;
    logic [15:0] value_i;
    logic [3:0]  dp_i;
    logic [3:0]  nibble_o;
    logic        dp_o;
    logic [3:0]  digit_en_n_o;
    logic        frame_o;
    logic        pending_o;

    int checks = 0;
    int errors = 0;

    // Reference model: cycles since reset release plus the shadow/active contents.
    int          t;
    logic [15:0] m_sh_val, m_act_val;
    logic [3:0]  m_sh_dp, m_act_dp;
    logic        m_pend;

    display_scan_controller #(
        .DIGITS       (DIGITS),
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (load_i),
        .value_i      (value_i),
        .dp_i         (dp_i),
        .nibble_o     (nibble_o),
        .dp_o         (dp_o),
        .digit_en_n_o (digit_en_n_o),
        .frame_o      (frame_o),
        .pending_o    (pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    function automatic logic [3:0] digit_of(input logic [15:0] v, input int d);
        return 4'((v >> (4 * d)) & 16'hF);
    endfunction

    function automatic bit lz_hidden(input int d);
        bit hidden;
        hidden = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0) begin
            hidden = 1'b1;
            for (int j = d; j < DIGITS; j++) begin
                if (digit_of(m_act_val, j) != 4'h0 || m_act_dp[j]) hidden = 1'b0;
            end
        end
`endif
        return hidden;
    endfunction

    task automatic check_all();
        int c;
        int d;
        logic [3:0] en;
        c = t % PRESCALE;
        d = (t / PRESCALE) % DIGITS;
        en = 4'hF;
        if (c >= BLANK && !lz_hidden(d)) en[d] = 1'b0;
        check("digit_en", 32'(digit_en_n_o), 32'(en));
        check("nibble", 32'(nibble_o), 32'(digit_of(m_act_val, d)));
        check("dp", 32'(dp_o), 32'(m_act_dp[d]));
        check("frame", 32'(frame_o), 32'((t > 0) && (t % FRAME == 0)));
        check("pending", 32'(pending_o), 32'(m_pend));
        check("onehot", 32'($countones(~digit_en_n_o) <= 1), 32'd1);
    endtask

    task automatic check_reset();
        check("rst_en", 32'(digit_en_n_o), 32'hF);
        check("rst_nibble", 32'(nibble_o), 32'h0);
        check("rst_dp", 32'(dp_o), 32'h0);
        check("rst_frame", 32'(frame_o), 32'h0);
        check("rst_pending", 32'(pending_o), 32'h0);
    endtask

    task automatic model_reset();
        t = 0;
        m_sh_val = '0;
        m_act_val = '0;
        m_sh_dp = '0;
        m_act_dp = '0;
        m_pend = 1'b0;
    endtask

    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] dp);
        load_i = ld;
        value_i = v;
        dp_i = dp;
        @(posedge clk);
        if (t % FRAME == FRAME - 1) begin
            if (m_pend) begin
                m_act_val = m_sh_val;
                m_act_dp = m_sh_dp;
            end
            m_pend = 1'b0;
        end
        if (ld) begin
            m_sh_val = v;
            m_sh_dp = dp;
            m_pend = 1'b1;
        end
        t++;
        #1;
        load_i = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0);
    endtask

    task automatic run_to_phase(input int ph);
        for (int i = 0; i < FRAME && (t % FRAME) != ph; i++) step(1'b0, 16'h0, 4'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        load_i = 1'b0;
        value_i = '0;
        dp_i = '0;
        model_reset();

        // Reset held, then released between edges.
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();
        idle(10);

        // Mid-frame load of 1234 with dp on digit 1, then two full frames.
        step(1'b1, 16'h1234, 4'b0010);
        idle(2 * FRAME);

        // Free run.
        idle(200);

        // Two loads in one frame; only the second may ever appear.
        run_to_phase(5);
        step(1'b1, 16'hAAAA, 4'h0);
        idle(6);
        step(1'b1, 16'h0BCD, 4'h0);
        idle(FRAME);

        // Load exactly on the boundary cycle: the older shadow transfers, the new one waits a frame.
        run_to_phase(FRAME - 3);
        step(1'b1, 16'h5678, 4'h1);
        idle(1);
        step(1'b1, 16'h9ABC, 4'h8);
        idle(2 * FRAME);

        // Leading-zero cases.
        step(1'b1, 16'h0070, 4'h0);
        idle(2 * FRAME);
        step(1'b1, 16'h0000, 4'h0);
        idle(2 * FRAME);
        step(1'b1, 16'h0005, 4'b0100);
        idle(2 * FRAME);

        // Reset mid-slot of digit 2 with a load still pending.
        step(1'b1, 16'h4321, 4'h3);
        idle(FRAME);
        step(1'b1, 16'hFEDC, 4'h0);
        run_to_phase(2 * PRESCALE + 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset();
        @(posedge clk);
        #1;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        check_all();
        idle(2 * FRAME);

        // Randomized loads.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                step(1'b1, 16'($urandom), 4'($urandom_range(0, 15)));
            end else begin
                idle(1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
